gray2rgb: RTL and testbench
===========================

# gray2rgb

Pseudocolor expander for the grayscale image path: accepts one width_p-bit gray pixel per handshake and emits an RGB triple through a two-stage valid/ready pipeline. It sits downstream of the RGB-to-grayscale converter and drives the RGB display/output stream. It uses the same valid/ready convention on both ports and sustains full throughput of one pixel per cycle.

## Interface
- width_p, default 8: bits per gray sample and per output color channel. Legal values are width_p >= 4.
- clk_i  in  1  clock. Every register updates on the rising edge.
- reset_ni  in  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- valid_i  in  1  upstream gray sample valid.
- gray_i  in  width_p  gray sample.
- ready_o  out  1  block can accept gray_i this cycle.
- valid_o  out  1  RGB triple valid.
- red_o  out  width_p  red channel.
- green_o  out  width_p  green channel.
- blue_o  out  width_p  blue channel.
- ready_i  in  1  downstream accepts the triple.

## Operation
- Stage 1 (S1) register holds v1, seg[1:0], and u[width_p-1:0]. It loads on the input handshake, valid_i && ready_o.
  - seg = gray_i[width_p-1:width_p-2].
  - f = gray_i[width_p-3:0].
  - u = {f, f[width_p-3:width_p-4]}. This is bit replication, so f=0 gives 0 and all-ones f gives MAX.
- Stage 2 (S2) register holds v2 and red/green/blue. It loads from S1 when v1 && ready1.
  - Let MAX = all ones and d = MAX - u.
  - seg 0: (0, u, MAX).
  - seg 1: (0, MAX, d).
  - seg 2: (u, MAX, 0).
  - seg 3: (MAX, d, 0).
- No multipliers. All arithmetic is unsigned and width_p wide. d cannot underflow.
- Pipeline control:
  - ready2 = ~v2 | ready_i.
  - ready1 = ~v1 | ready2.
  - ready_o = ready1. This is a combinational path from ready_i.
- v1 next value:
  - set on input handshake;
  - else cleared when S1 moves to S2;
  - else held.
- v2 next value:
  - set when S1 moves to S2;
  - else cleared on valid_o && ready_i;
  - else held.
- Data registers load only when their stage accepts. They hold otherwise, including while stalled.

## Timing
- Latency: a sample accepted at edge N appears on valid_o/RGB after edge N+1, i.e. 2 registers.
- Throughput: 1 pixel/cycle when ready_i stays high.
- Stall (ready_i low):
  - S2 holds its triple stable and valid_o stays high.
  - S1 still accepts one more sample if empty, then ready_o drops.
  - At most 2 samples are buffered.
- Outputs must not change while valid_o && !ready_i.
- Simultaneous events:
  - When S2 drains and S1 advances in the same cycle, v2 stays 1 with the new data.
  - When S1 is refilled and drained in the same cycle, v1 stays 1.
  - No bubbles and no duplicates.
- Reset (reset_ni low at an edge):
  - v1 = v2 = 0 and valid_o = 0.
  - ready_o = 1 combinationally (since v1 = 0).
  - red_o, green_o, blue_o reset to 0. seg/u reset to 0.
- Reset mid-stream discards both buffered samples. The first post-reset output is the first sample accepted after reset_ni returns high.
- valid_o never depends combinationally on valid_i.

## Configuration
- GRAY2RGB_PSEUDOCOLOR_EN defined: the colormap above is active.
- Not defined:
  - S2 loads red = green = blue = the S1-registered gray value, which is stored in place of seg/u.
  - This is a neutral gray expansion with identical handshake, latency, and reset behaviour.
  - The seg/u decode logic is absent.

## Test plan
All cases use width_p = 8.
- Reset: hold reset_ni low 3 cycles with valid_i = 1 → valid_o = 0, RGB = 0, ready_o = 1 throughout. The first sample after release emerges after exactly 2 edges.
- Colormap sweep with ready_i = 1 and PSEUDOCOLOR_EN defined, feeding gray 0, 63, 64, 100, 127, 128, 200, 255 back-to-back → outputs on consecutive cycles:
  - (0,0,255), (0,255,255), (0,255,255), (0,255,109), (0,255,0), (0,255,0), (255,223,0), (255,0,0).
  - No gaps.
- Backpressure: stream 10 samples while ready_i toggles in a 1-on/2-off pattern → all 10 triples arrive in order, with no loss or duplication. ready_o goes low only when both stages are full. RGB is stable whenever valid_o && !ready_i.
- Full-pipe simultaneous drain/fill: with both stages full, raise ready_i and assert valid_i in the same cycle → the input is accepted, valid_o stays high, and the next triple appears on the following cycle.
- Reset mid-stream: reset while 2 samples are buffered and ready_i = 0 → neither sample is ever output. The post-reset gray 100 yields (0,255,109).
- Macro off: feed gray 0, 77, 255 → outputs (0,0,0), (77,77,77), (255,255,255) with 2-cycle latency.

Source files
------------

// File: rtl/gray2rgb.sv
// Gray-to-RGB expander: two-stage valid/ready pipeline, one pixel per cycle.
// Define GRAY2RGB_PSEUDOCOLOR_EN for the four-segment colormap; otherwise gray is copied to R/G/B.
module gray2rgb #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               valid_i,
    input  logic [width_p-1:0] gray_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] red_o,
    output logic [width_p-1:0] green_o,
    output logic [width_p-1:0] blue_o,
    input  logic               ready_i
);

    logic               v1, v2;
    logic               ready1, ready2;
    logic               in_hs, s1_to_s2, out_hs;
    logic [width_p-1:0] red_q, green_q, blue_q;
    logic [width_p-1:0] red_d, green_d, blue_d;

    assign ready2   = ~v2 | ready_i;
    assign ready1   = ~v1 | ready2;
    assign ready_o  = ready1;
    assign in_hs    = valid_i & ready1;
    assign s1_to_s2 = v1 & ready2;
    assign out_hs   = v2 & ready_i;

`ifdef GRAY2RGB_PSEUDOCOLOR_EN
    localparam logic [width_p-1:0] max_c = '1;

    logic [1:0]         seg_q;
    logic [width_p-1:0] u_q, u_d, d_s;

    // Replicating the top fraction bits stretches f to the full channel range.
    assign u_d = {gray_i[width_p-3:0], gray_i[width_p-3:width_p-4]};

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            seg_q <= '0;
            u_q   <= '0;
        end else if (in_hs) begin
            seg_q <= gray_i[width_p-1:width_p-2];
            u_q   <= u_d;
        end
    end

    assign d_s = max_c - u_q;

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        case (seg_q)
            2'd0: begin green_d = u_q;   blue_d  = max_c; end
            2'd1: begin green_d = max_c; blue_d  = d_s;   end
            2'd2: begin red_d   = u_q;   green_d = max_c; end
            default: begin red_d = max_c; green_d = d_s;  end
        endcase
    end
`else
    logic [width_p-1:0] gray_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            gray_q <= '0;
        end else if (in_hs) begin
            gray_q <= gray_i;
        end
    end

    assign red_d   = gray_q;
    assign green_d = gray_q;
    assign blue_d  = gray_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (in_hs)         v1 <= 1'b1;
            else if (s1_to_s2) v1 <= 1'b0;

            if (s1_to_s2)      v2 <= 1'b1;
            else if (out_hs)   v2 <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (s1_to_s2) begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign valid_o = v2;
    assign red_o   = red_q;
    assign green_o = green_q;
    assign blue_o  = blue_q;

endmodule

// File: tb/tb_gray2rgb.sv
// Self-checking bench for gray2rgb: directed phases plus random traffic against a queue model.
module tb_gray2rgb;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       valid_i;
    logic [7:0] gray_i;
    logic       ready_o;
    logic       valid_o;
    logic [7:0] red_o, green_o, blue_o;
    logic       ready_i;

    int checks_total  = 0;
    int checks_passed = 0;
    int edge_cnt      = 0;

    logic [23:0] q_rgb[$];
    int          q_t[$];
    logic        stall_prev = 1'b0;
    logic [23:0] held_rgb   = '0;

    gray2rgb #(.width_p(8)) dut (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .valid_i (valid_i),
        .gray_i  (gray_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .red_o   (red_o),
        .green_o (green_o),
        .blue_o  (blue_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Expected triple straight from the colormap rules, using plain integer arithmetic.
    function automatic logic [23:0] ref_rgb(input int g);
`ifdef GRAY2RGB_PSEUDOCOLOR_EN
        int seg, f, u, d, r, gr, b;
        seg = g / 64;
        f   = g % 64;
        u   = f * 4 + f / 16;
        d   = 255 - u;
        case (seg)
            0:       begin r = 0;   gr = u;   b = 255; end
            1:       begin r = 0;   gr = 255; b = d;   end
            2:       begin r = u;   gr = 255; b = 0;   end
            default: begin r = 255; gr = d;   b = 0;   end
        endcase
        return {r[7:0], gr[7:0], b[7:0]};
`else
        return {g[7:0], g[7:0], g[7:0]};
`endif
    endfunction

    // One clock of traffic: drive, check against the model, then advance the model across the edge.
    task automatic step(input logic v, input logic [7:0] g, input logic r, output logic accepted);
        logic exp_valid, exp_ready;
        @(negedge clk_i);
        valid_i = v;
        gray_i  = g;
        ready_i = r;
        #1;
        exp_valid = (q_rgb.size() > 0) && ((edge_cnt - q_t[0]) >= 1);
        exp_ready = (q_rgb.size() < 2) || r;
        check("valid_o", {31'd0, valid_o}, {31'd0, exp_valid});
        check("ready_o", {31'd0, ready_o}, {31'd0, exp_ready});
        if (exp_valid) check("rgb", {8'd0, red_o, green_o, blue_o}, {8'd0, q_rgb[0]});
        if (stall_prev) check("stall_hold", {8'd0, red_o, green_o, blue_o}, {8'd0, held_rgb});
        stall_prev = exp_valid && !r;
        held_rgb   = {red_o, green_o, blue_o};
        accepted   = v && exp_ready;
        @(posedge clk_i);
        edge_cnt++;
        if (exp_valid && r) begin
            void'(q_rgb.pop_front());
            void'(q_t.pop_front());
        end
        if (accepted) begin
            q_rgb.push_back(ref_rgb(int'(g)));
            q_t.push_back(edge_cnt);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            reset_ni = 1'b0;
            valid_i  = 1'b1;
            gray_i   = 8'($urandom);
            ready_i  = 1'b1;
            @(posedge clk_i);
            edge_cnt++;
            #1;
            check("rst_valid_o", {31'd0, valid_o}, 32'd0);
            check("rst_ready_o", {31'd0, ready_o}, 32'd1);
            check("rst_rgb", {8'd0, red_o, green_o, blue_o}, 32'd0);
        end
        q_rgb.delete();
        q_t.delete();
        stall_prev = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        valid_i  = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 8 && q_rgb.size() > 0; i++) step(1'b0, 8'd0, 1'b1, acc);
        check("drain_empty", q_rgb.size(), 32'd0);
    endtask

    initial begin
        logic acc;
        int   sent;
        logic [7:0] sweep[8];
        sweep = '{8'd0, 8'd63, 8'd64, 8'd100, 8'd127, 8'd128, 8'd200, 8'd255};

        reset_ni = 1'b0;
        valid_i  = 1'b0;
        gray_i   = '0;
        ready_i  = 1'b1;
        do_reset(3);

        // Back-to-back sweep across all four segments.
        for (int i = 0; i < 8; i++) step(1'b1, sweep[i], 1'b1, acc);
        drain();

        // Backpressure: ready_i one cycle on, two off.
        sent = 0;
        for (int k = 0; k < 80 && (sent < 10 || q_rgb.size() > 0); k++) begin
            step(sent < 10, 8'(17 * sent + 5), (k % 3) == 0, acc);
            if (acc) sent++;
        end
        check("bp_sent", sent, 32'd10);
        check("bp_empty", q_rgb.size(), 32'd0);

        // Fill both stages, then drain and refill in the same cycle.
        step(1'b1, 8'd40, 1'b0, acc);
        step(1'b1, 8'd150, 1'b0, acc);
        step(1'b1, 8'd77, 1'b0, acc);
        check("full_refused", {31'd0, acc}, 32'd0);
        step(1'b1, 8'd77, 1'b1, acc);
        check("full_fill_drain", {31'd0, acc}, 32'd1);
        step(1'b0, 8'd0, 1'b1, acc);
        drain();

        // Mid-stream reset with two samples stuck behind ready_i low.
        step(1'b1, 8'd11, 1'b0, acc);
        step(1'b1, 8'd222, 1'b0, acc);
        step(1'b0, 8'd0, 1'b0, acc);
        do_reset(1);
        step(1'b1, 8'd100, 1'b1, acc);
        step(1'b0, 8'd0, 1'b1, acc);
        step(1'b0, 8'd0, 1'b1, acc);
        drain();

        // Random traffic.
        for (int k = 0; k < 400; k++)
            step(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), acc);
        drain();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
